conv_sequencer: RTL

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_mac.sv | 33 +++
 rtl/conv_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the direct-form convolution sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    DONE
  } conv_state_t;

  // Sum of up to 2**addr_w products of two data_w-bit signed samples
  function automatic int calc_zw(input int data_w, input int addr_w);
    return 2 * data_w + addr_w;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with synchronous clear; the product and sum share one stage.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ZW         = calc_zw(8, 4)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [ZW-1:0]         acc_o
);

  logic signed [2*DATA_WIDTH-1:0] w_prod_p0;
  logic signed [ZW-1:0]           r_acc_p1;

  assign w_prod_p0 = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);

  // p0 -> p1: accumulate the sign-extended product
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      r_acc_p1 <= '0;
    end else if (en_i) begin
      r_acc_p1 <= r_acc_p1 + ZW'(w_prod_p0);
    end
  end

  assign acc_o = r_acc_p1;

endmodule

// File: rtl/conv_sequencer.sv
// Walks every (k, n-k) term of z = x * y against external 1-cycle-latency RAMs
// and writes each output sample once its terms have been accumulated.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  ADDR_WIDTH = 4,
  localparam int ZW         = calc_zw(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [ADDR_WIDTH:0]          size_x_i,
  input  logic [ADDR_WIDTH:0]          size_y_i,
  output logic [ADDR_WIDTH-1:0]        x_addr_o,
  output logic [ADDR_WIDTH-1:0]        y_addr_o,
  input  logic signed [DATA_WIDTH-1:0] x_data_i,
  input  logic signed [DATA_WIDTH-1:0] y_data_i,
  output logic                         z_we_o,
  output logic [ADDR_WIDTH:0]          z_addr_o,
  output logic signed [ZW-1:0]         z_data_o,
  output logic                         busy_o,
  output logic                         done_o
);

  // Two spare bits so N+M and n+2 never wrap
  localparam int             CW      = ADDR_WIDTH + 2;
  localparam logic [CW-1:0]  MAX_LEN = CW'(1) << ADDR_WIDTH;

  function automatic logic [CW-1:0] sat_len(input logic [ADDR_WIDTH:0] len);
    logic [CW-1:0] ext;
    ext = {1'b0, len};
    return (ext > MAX_LEN) ? MAX_LEN : ext;
  endfunction

  // First valid k for output n: max(0, n-M+1)
  function automatic logic [CW-1:0] first_k(input logic [CW-1:0] n,
                                            input logic [CW-1:0] m);
    return (n >= m) ? (n - m + CW'(1)) : '0;
  endfunction

  conv_state_t          r_state, w_next;
  logic [CW-1:0]        r_len_x, r_len_y;
  logic [CW-1:0]        r_n, r_k;
  logic [CW-1:0]        w_kmax;
  logic                 w_last_n;
  logic                 w_mac_clr;
  logic                 r_fetch_vld_p1;
  logic signed [ZW-1:0] w_acc;

  assign w_kmax    = (r_n < r_len_x) ? r_n : (r_len_x - CW'(1));
  assign w_last_n  = (r_n + CW'(2)) == (r_len_x + r_len_y);
  assign w_mac_clr = (r_state == IDLE) || (r_state == WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_len_x        <= '0;
      r_len_y        <= '0;
      r_n            <= '0;
      r_k            <= '0;
      r_fetch_vld_p1 <= 1'b0;
    end else begin
      r_state        <= w_next;
      // p0 -> p1: RAM data for a FETCH address arrives one cycle later
      r_fetch_vld_p1 <= (r_state == FETCH);
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_len_x <= sat_len(size_x_i);
            r_len_y <= sat_len(size_y_i);
            r_n     <= '0;
            r_k     <= '0;
          end
        end
        FETCH: r_k <= r_k + CW'(1);
        WRITE: begin
          r_n <= r_n + CW'(1);
          r_k <= first_k(r_n + CW'(1), r_len_y);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    x_addr_o = '0;
    y_addr_o = '0;
    z_we_o   = 1'b0;
    z_addr_o = '0;
    z_data_o = '0;
    busy_o   = 1'b1;
    done_o   = 1'b0;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_next = (size_x_i == '0 || size_y_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        x_addr_o = r_k[ADDR_WIDTH-1:0];
        y_addr_o = ADDR_WIDTH'(r_n - r_k);
        if (r_k == w_kmax) w_next = DRAIN;
      end
      DRAIN: w_next = WRITE;
      WRITE: begin
        z_we_o   = 1'b1;
        z_addr_o = r_n[ADDR_WIDTH:0];
        z_data_o = w_acc;
        w_next   = w_last_n ? DONE : FETCH;
      end
      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  conv_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ZW        (ZW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(w_mac_clr),
    .en_i (r_fetch_vld_p1),
    .a_i  (x_data_i),
    .b_i  (y_data_i),
    .acc_o(w_acc)
  );

endmodule
